// File: rtl/matmul_apb_master.sv
// APB master for the matmul block: accepts one command at a time, runs a
// SETUP/ACCESS transfer with a bounded wait, and returns the result through a
// valid/ready response port. All outputs are registered.
module matmul_apb_master #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned BUS_WIDTH   = 64,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_write_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
   input  logic [MAX_DIM-1:0]    cmd_strb_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  rsp_timeout_o,
   output logic                  psel_o,
   output logic                  penable_o,
   output logic                  pwrite_o,
   output logic [ADDR_WIDTH-1:0] paddr_o,
   output logic [BUS_WIDTH-1:0]  pwdata_o,
   output logic [MAX_DIM-1:0]    pstrb_o,
   input  logic                  pready_i,
   input  logic                  pslverr_i,
   input  logic [BUS_WIDTH-1:0]  prdata_i,
   output logic                  busy_o
);

   localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   // Count value held during the last permitted wait cycle.
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;

   // Transfer sequencer: state, wait counter and every registered output.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state         <= IDLE;
         wait_cnt      <= '0;
         cmd_ready_o   <= 1'b1;
         rsp_valid_o   <= 1'b0;
         rsp_rdata_o   <= '0;
         rsp_err_o     <= 1'b0;
         rsp_timeout_o <= 1'b0;
         psel_o        <= 1'b0;
         penable_o     <= 1'b0;
         pwrite_o      <= 1'b0;
         paddr_o       <= '0;
         pwdata_o      <= '0;
         pstrb_o       <= '0;
         busy_o        <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (cmd_valid_i) begin
                  state       <= SETUP;
                  cmd_ready_o <= 1'b0;
                  busy_o      <= 1'b1;
                  psel_o      <= 1'b1;
                  pwrite_o    <= cmd_write_i;
                  paddr_o     <= cmd_addr_i;
                  // Reads drive neither data nor strobes onto the bus.
                  pwdata_o    <= cmd_write_i ? cmd_wdata_i : '0;
                  pstrb_o     <= cmd_write_i ? cmd_strb_i  : '0;
               end
            end
            SETUP: begin
               state     <= ACCESS;
               penable_o <= 1'b1;
               wait_cnt  <= '0;
            end
            ACCESS: begin
               // A ready slave takes priority over an expiring wait budget.
               if (pready_i) begin
                  state         <= RESP;
                  psel_o        <= 1'b0;
                  penable_o     <= 1'b0;
                  rsp_valid_o   <= 1'b1;
                  rsp_err_o     <= pslverr_i;
                  rsp_timeout_o <= 1'b0;
                  rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
               end else if (wait_cnt == LAST_WAIT) begin
                  state         <= RESP;
                  psel_o        <= 1'b0;
                  penable_o     <= 1'b0;
                  rsp_valid_o   <= 1'b1;
                  rsp_err_o     <= 1'b1;
                  rsp_timeout_o <= 1'b1;
                  rsp_rdata_o   <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  state         <= IDLE;
                  cmd_ready_o   <= 1'b1;
                  busy_o        <= 1'b0;
                  rsp_valid_o   <= 1'b0;
                  rsp_err_o     <= 1'b0;
                  rsp_timeout_o <= 1'b0;
                  rsp_rdata_o   <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/matmul_apb_master.md
MATMUL_APB_MASTER -- requirements
Module: matmul_apb_master

Interface
REQ-001 Parameter DATA_WIDTH, default 32, matrix element width in bits.
REQ-002 Parameter BUS_WIDTH, default 64, APB data width in bits.
REQ-003 Parameter ADDR_WIDTH, default 32, APB address width in bits.
REQ-004 Parameter MAX_DIM, default BUS_WIDTH/DATA_WIDTH (2), elements per bus word and strobe width.
REQ-005 Parameter TIMEOUT_CYC, default 16, maximum ACCESS cycles before abort.
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-007 clk_i  input  1  clock; all state on rising edge.
REQ-008 rst_ni  input  1  asynchronous, active-low reset.
REQ-009 cmd_valid_i  input  1  command request.
REQ-010 cmd_ready_o  output  1  command accepted when high with cmd_valid_i.
REQ-011 cmd_write_i  input  1  1 = write, 0 = read.
REQ-012 cmd_addr_i  input  ADDR_WIDTH  target address.
REQ-013 cmd_wdata_i  input  BUS_WIDTH  write data.
REQ-014 cmd_strb_i  input  MAX_DIM  per-element write strobe.
REQ-015 rsp_valid_o  output  1  response available.
REQ-016 rsp_ready_i  input  1  response consumed when high with rsp_valid_o.
REQ-017 rsp_rdata_o  output  BUS_WIDTH  read data; 0 for writes.
REQ-018 rsp_err_o  output  1  slave error or timeout.
REQ-019 rsp_timeout_o  output  1  transfer aborted by timeout.
REQ-020 psel_o, penable_o, pwrite_o  output  1 each  APB control.
REQ-021 paddr_o  output  ADDR_WIDTH; pwdata_o  output  BUS_WIDTH; pstrb_o  output  MAX_DIM.
REQ-022 pready_i, pslverr_i  input  1 each; prdata_i  input  BUS_WIDTH.
REQ-023 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-024 The FSM SHALL have states IDLE, SETUP, ACCESS, RESP.
REQ-025 cmd_ready_o SHALL be high only in IDLE; cmd_valid_i in any other state is ignored.
REQ-026 On accept in IDLE, the block SHALL latch write/addr/wdata/strb and enter SETUP next cycle.
REQ-027 SETUP: psel_o=1, penable_o=0, exactly one cycle, then ACCESS.
REQ-028 ACCESS: psel_o=1, penable_o=1; paddr/pwrite/pwdata/pstrb held stable until exit.
REQ-029 pstrb_o SHALL be 0 for reads; pwdata_o SHALL be 0 for reads.
REQ-030 In ACCESS with pready_i=1, the block SHALL capture prdata_i (reads only) and pslverr_i into the response and enter RESP.
REQ-031 pslverr_i and prdata_i SHALL be ignored unless pready_i=1 in ACCESS.
REQ-032 A wait counter SHALL reset on entering ACCESS and increment per ACCESS cycle with pready_i=0; at TIMEOUT_CYC consecutive waits, enter RESP with rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
REQ-033 pready_i=1 on the same cycle the limit is reached SHALL win (normal completion, no timeout).
REQ-034 RESP: psel_o=0, penable_o=0, rsp_valid_o=1; response fields stable until rsp_ready_i=1, then IDLE.
REQ-035 Minimum latency: accept at cycle T, SETUP T+1, ACCESS T+2, rsp_valid_o at T+3 when pready_i=1 at T+2.
REQ-036 paddr_o/pwrite_o SHALL hold last values outside transfers.

Reset
REQ-037 rst_ni low SHALL immediately force IDLE and all outputs to 0 except cmd_ready_o=1, including mid-transfer (psel_o/penable_o drop asynchronously); no response is issued for an aborted transfer.

Verification
REQ-038 Write addr 0x10, data 0x0000_0002_0000_0001, strb 2'b11, pready=1 first ACCESS -> SETUP T+1, ACCESS T+2, rsp_valid T+3, err=0, rdata=0.
REQ-039 Read addr 0x20, pready low 3 cycles, prdata=0xDEAD_BEEF_0123_4567 -> 4 ACCESS cycles, rsp_rdata matches, pstrb_o=0 throughout.
REQ-040 Write with pslverr=1 at pready -> rsp_err=1, rsp_timeout=0.
REQ-041 pready never asserted -> after 16 wait cycles rsp_err=1, rsp_timeout=1, psel_o low in RESP.
REQ-042 rsp_ready held low 5 cycles with cmd_valid high -> cmd_ready stays 0, response stable, second command accepted only after IDLE.
REQ-043 rst_ni low during ACCESS -> psel_o/penable_o 0 same cycle, busy_o=0, no rsp_valid_o after release.
